// File: rtl/regfile_wport_sched_if.sv
// Write-port bundle for regfile_wport_sched: two write requesters plus the
// registered register-file write outputs and the init-done flag.
interface regfile_wport_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rf_w;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_c;
  logic              init_done;

  modport master (
    output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready, rf_w, rf_rd, rf_c, init_done
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready, rf_w, rf_rd, rf_c, init_done
  );
endinterface

// File: rtl/regfile_wport_sched.sv
// Register-file write-port scheduler: sweeps every register to INIT_VALUE after
// reset, then round-robins two write requesters onto a single registered port.
module regfile_wport_sched #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 5,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic                  clock,
  input logic                  reset,
  regfile_wport_sched_if.slave wp
);
  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W:0]   init_cnt;   // MSB flags that the sweep has covered every register
  logic              last_grant;
  logic              rf_w_q;
  logic [ADDR_W-1:0] rf_rd_q;
  logic [DATA_W-1:0] rf_c_q;
  logic              init_done_q;

  logic              run, gnt0, gnt1, xfer, keep;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  // last_grant=1 means requester 1 won most recently, so requester 0 takes the tie
  always_comb begin
    run      = (state == RUN);
    gnt0     = run & wp.req0_valid & (~wp.req1_valid | last_grant);
    gnt1     = run & wp.req1_valid & (~wp.req0_valid | ~last_grant);
    xfer     = gnt0 | gnt1;
    sel_rd   = gnt1 ? wp.req1_rd   : wp.req0_rd;
    sel_data = gnt1 ? wp.req1_data : wp.req0_data;
    keep     = xfer & (sel_rd != '0);
  end

  assign wp.req0_ready = gnt0;
  assign wp.req1_ready = gnt1;
  assign wp.rf_w       = rf_w_q;
  assign wp.rf_rd      = rf_rd_q;
  assign wp.rf_c       = rf_c_q;
  assign wp.init_done  = init_done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      init_cnt    <= '0;
      last_grant  <= 1'b1;
      rf_w_q      <= 1'b0;
      rf_rd_q     <= '0;
      rf_c_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (!init_cnt[ADDR_W]) begin
            rf_w_q   <= 1'b1;
            rf_rd_q  <= init_cnt[ADDR_W-1:0];
            rf_c_q   <= INIT_VALUE;
            init_cnt <= init_cnt + CNT_ONE;
          end else begin
            state       <= RUN;
            init_done_q <= 1'b1;
            rf_w_q      <= 1'b0;
          end
        end
        RUN: begin
          // writes to register 0 are accepted but dropped, leaving rd/c untouched
          rf_w_q <= keep;
          if (keep) begin
            rf_rd_q <= sel_rd;
            rf_c_q  <= sel_data;
          end
          if (xfer) last_grant <= gnt1;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
